hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter RNBITS, default 5, register-number width.
REQ-002 SHALL have parameter MUXBITS, default 3, forward-select width per channel.
REQ-003 SHALL have parameter NSRC, default 2, number of EX-stage source channels (range 1..4).
REQ-004 SHALL have parameter LOAD_LAT, default 1, stall cycles per load-use hazard (range 1..7).
REQ-005 SHALL have parameter CNTBITS, default 16, stall-counter width.
REQ-006 SHALL use one clock and a synchronous, active-high reset; clock and reset are i_clk and i_reset, which precede all other ports.
REQ-007 i_clk  input  1  system clock, all state on rising edge.
REQ-008 i_reset  input  1  synchronous active-high reset.
REQ-009 i_EX_MEM_RegWrite  input  1  EX/MEM instruction writes the register file.
REQ-010 i_EX_MEM_Rd  input  RNBITS  EX/MEM destination register.
REQ-011 i_MEM_WR_RegWrite  input  1  MEM/WB instruction writes the register file.
REQ-012 i_MEM_WR_Rd  input  RNBITS  MEM/WB destination register.
REQ-013 i_src  input  NSRC*RNBITS  EX-stage source registers, channel k at bits [k*RNBITS +: RNBITS].
REQ-014 i_ID_EX_MemRead  input  1  instruction currently in EX is a load.
REQ-015 i_ID_EX_Rt  input  RNBITS  load destination register.
REQ-016 i_IF_ID_valid  input  1  ID stage holds a real instruction.
REQ-017 i_IF_ID_rs, i_IF_ID_rt  input  RNBITS each  ID-stage source registers.
REQ-018 i_count_clr  input  1  synchronous clear of the stall counter.
REQ-019 o_mux  output  NSRC*MUXBITS  per-channel forward select, channel k at [k*MUXBITS +: MUXBITS].
REQ-020 o_stall  output  1  hold PC and IF/ID.
REQ-021 o_flush_ID_EX  output  1  insert bubble into ID/EX.
REQ-022 o_stall_count  output  CNTBITS  total stall cycles since reset/clear.

Function
REQ-023 Forward select SHALL be combinational per channel: 001 if EX/MEM RegWrite and Rd==src and Rd!=0; else 010 if MEM/WB RegWrite and Rd==src and Rd!=0; else 000.
REQ-024 EX/MEM SHALL take priority over MEM/WB when both match the same channel.
REQ-025 Register 0 SHALL never be forwarded; src==0 always yields 000.
REQ-026 Hazard SHALL be detected when i_ID_EX_MemRead, i_ID_EX_Rt!=0, i_IF_ID_valid, and (i_IF_ID_rs==i_ID_EX_Rt or i_IF_ID_rt==i_ID_EX_Rt).
REQ-027 FSM states SHALL be RUN and STALL; reset state RUN.
REQ-028 In RUN, a hazard SHALL assert o_stall and o_flush_ID_EX combinationally in the same cycle.
REQ-029 In RUN with hazard and LOAD_LAT>1, the FSM SHALL go to STALL with remaining count LOAD_LAT-1; with LOAD_LAT==1 it SHALL stay in RUN.
REQ-030 In STALL, o_stall and o_flush_ID_EX SHALL be 1 every cycle, count decrements, and the FSM SHALL return to RUN in the cycle the count reaches 1, giving exactly LOAD_LAT stall cycles per hazard.
REQ-031 Hazard inputs SHALL be ignored while in STALL.
REQ-032 o_stall_count SHALL increment on each cycle with o_stall=1 and saturate at all-ones.
REQ-033 i_count_clr SHALL set the counter to 0 next edge and take priority over a simultaneous increment.
REQ-034 o_mux SHALL be independent of FSM state.

Reset
REQ-035 While i_reset=1, o_stall, o_flush_ID_EX and o_mux SHALL be 0.
REQ-036 After a reset edge, state SHALL be RUN, remaining count 0, and o_stall_count 0.
REQ-037 Reset asserted mid-STALL SHALL abort the stall; no stall cycle SHALL follow reset release unless a new hazard is present.

Structure
REQ-038 Shared package SHALL hold FWD_RF=000, FWD_EXMEM=001, FWD_MEMWB=010 and the RUN/STALL state encoding.
REQ-039 One sub-module, fwd_select (single-channel comparator per REQ-023..025), SHALL be instantiated NSRC times via generate.

Verification
REQ-040 EX/MEM Rd=5 RegWrite=1, MEM/WB Rd=5 RegWrite=1, src0=5 -> o_mux ch0=001 (priority).
REQ-041 EX/MEM Rd=0 RegWrite=1, src0=0, src1=0 -> both channels 000.
REQ-042 NSRC=3, src2=9, MEM/WB Rd=9 RegWrite=1 -> ch2=010, ch0/ch1=000.
REQ-043 LOAD_LAT=1: MemRead=1, Rt=7, IF_ID_rt=7, valid=1 -> stall/flush=1 one cycle, counter 0->1.
REQ-044 LOAD_LAT=3, same hazard held -> exactly 3 stall cycles, then RUN; counter +3; reset in 2nd stall cycle -> stall 0 after release, counter 0.
REQ-045 CNTBITS=4, 20 stall cycles -> counter holds 15; i_count_clr with stall -> counter 0.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard / forwarding unit.
package hazard_forward_unit_pkg;

  // Forward-select codes (zero-extended to the configured select width).
  localparam logic [2:0] FWD_RF    = 3'b000;
  localparam logic [2:0] FWD_EXMEM = 3'b001;
  localparam logic [2:0] FWD_MEMWB = 3'b010;

  // Remaining-stall counter width; LOAD_LAT never exceeds 7.
  localparam int REMBITS = 3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Single-channel forwarding comparator: picks EX/MEM, then MEM/WB, else register file.
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int RNBITS  = 5,
  parameter int MUXBITS = 3
) (
  input  logic              i_ex_mem_regwrite,
  input  logic [RNBITS-1:0] i_ex_mem_rd,
  input  logic              i_mem_wr_regwrite,
  input  logic [RNBITS-1:0] i_mem_wr_rd,
  input  logic [RNBITS-1:0] i_src,
  output logic [MUXBITS-1:0] o_sel
);

  // EX/MEM holds the youngest value, so it wins; register 0 is never forwarded.
  always_comb begin
    o_sel = MUXBITS'(FWD_RF);
    if (i_ex_mem_regwrite && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_src))
      o_sel = MUXBITS'(FWD_EXMEM);
    else if (i_mem_wr_regwrite && (i_mem_wr_rd != '0) && (i_mem_wr_rd == i_src))
      o_sel = MUXBITS'(FWD_MEMWB);
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Data-forwarding selects plus load-use stall FSM and saturating stall counter.
module hazard_forward_unit #(
  parameter int RNBITS   = 5,
  parameter int MUXBITS  = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNTBITS  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_EX_MEM_RegWrite,
  input  logic [RNBITS-1:0]         i_EX_MEM_Rd,
  input  logic                      i_MEM_WR_RegWrite,
  input  logic [RNBITS-1:0]         i_MEM_WR_Rd,
  input  logic [NSRC*RNBITS-1:0]    i_src,
  input  logic                      i_ID_EX_MemRead,
  input  logic [RNBITS-1:0]         i_ID_EX_Rt,
  input  logic                      i_IF_ID_valid,
  input  logic [RNBITS-1:0]         i_IF_ID_rs,
  input  logic [RNBITS-1:0]         i_IF_ID_rt,
  input  logic                      i_count_clr,
  output logic [NSRC*MUXBITS-1:0]   o_mux,
  output logic                      o_stall,
  output logic                      o_flush_ID_EX,
  output logic [CNTBITS-1:0]        o_stall_count
);
  import hazard_forward_unit_pkg::*;

  // ---------------- forwarding ----------------
  for (genvar k = 0; k < NSRC; k++) begin : g_ch
    logic [MUXBITS-1:0] sel;

    fwd_select #(.RNBITS(RNBITS), .MUXBITS(MUXBITS)) u_sel (
      .i_ex_mem_regwrite (i_EX_MEM_RegWrite),
      .i_ex_mem_rd       (i_EX_MEM_Rd),
      .i_mem_wr_regwrite (i_MEM_WR_RegWrite),
      .i_mem_wr_rd       (i_MEM_WR_Rd),
      .i_src             (i_src[k*RNBITS +: RNBITS]),
      .o_sel             (sel)
    );

    // Selects are forced to register-file while reset is held.
    assign o_mux[k*MUXBITS +: MUXBITS] = i_reset ? '0 : sel;
  end

  // ---------------- load-use stall FSM ----------------
  state_t             state_q, state_d;
  logic [REMBITS-1:0] rem_q, rem_d;
  logic               hazard;
  logic               stall;

  assign hazard = i_ID_EX_MemRead && (i_ID_EX_Rt != '0) && i_IF_ID_valid &&
                  ((i_IF_ID_rs == i_ID_EX_Rt) || (i_IF_ID_rt == i_ID_EX_Rt));

  // State and remaining-stall register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state: first stall cycle is the detection cycle, STALL covers the rest.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            rem_d   = REMBITS'(LOAD_LAT - 1);
          end
        end
      end
      STALL: begin
        stall = 1'b1;
        if (rem_q <= REMBITS'(1)) begin
          state_d = RUN;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - REMBITS'(1);
        end
      end
      default: begin
        state_d = RUN;
        rem_d   = '0;
      end
    endcase
  end

  assign o_stall       = stall && !i_reset;
  assign o_flush_ID_EX = stall && !i_reset;

  // ---------------- stall counter ----------------
  logic [CNTBITS-1:0] cnt_q, cnt_d;

  // Clear beats increment; increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_count_clr)
      cnt_d = '0;
    else if (o_stall && !(&cnt_q))
      cnt_d = cnt_q + CNTBITS'(1);
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: u0 (NSRC=3, LOAD_LAT=3, CNTBITS=16), u1 (NSRC=2, LOAD_LAT=1, CNTBITS=4).
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_rw, mw_rw, memread, valid, clr;
  logic [4:0] ex_rd, mw_rd, id_rt, if_rs, if_rt;
  logic [4:0] s0, s1, s2;

  logic [8:0]  mux0;
  logic        stall0, flush0;
  logic [15:0] cnt0;
  logic [5:0]  mux1;
  logic        stall1, flush1;
  logic [3:0]  cnt1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.RNBITS(5), .MUXBITS(3), .NSRC(3), .LOAD_LAT(3), .CNTBITS(16)) u0 (
    .i_clk(clk), .i_reset(rst),
    .i_EX_MEM_RegWrite(ex_rw), .i_EX_MEM_Rd(ex_rd),
    .i_MEM_WR_RegWrite(mw_rw), .i_MEM_WR_Rd(mw_rd),
    .i_src({s2, s1, s0}),
    .i_ID_EX_MemRead(memread), .i_ID_EX_Rt(id_rt),
    .i_IF_ID_valid(valid), .i_IF_ID_rs(if_rs), .i_IF_ID_rt(if_rt),
    .i_count_clr(clr),
    .o_mux(mux0), .o_stall(stall0), .o_flush_ID_EX(flush0), .o_stall_count(cnt0)
  );

  hazard_forward_unit #(.RNBITS(5), .MUXBITS(3), .NSRC(2), .LOAD_LAT(1), .CNTBITS(4)) u1 (
    .i_clk(clk), .i_reset(rst),
    .i_EX_MEM_RegWrite(ex_rw), .i_EX_MEM_Rd(ex_rd),
    .i_MEM_WR_RegWrite(mw_rw), .i_MEM_WR_Rd(mw_rd),
    .i_src({s1, s0}),
    .i_ID_EX_MemRead(memread), .i_ID_EX_Rt(id_rt),
    .i_IF_ID_valid(valid), .i_IF_ID_rs(if_rs), .i_IF_ID_rt(if_rt),
    .i_count_clr(clr),
    .o_mux(mux1), .o_stall(stall1), .o_flush_ID_EX(flush1), .o_stall_count(cnt1)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ex_rw = 0; ex_rd = 0; mw_rw = 0; mw_rd = 0;
    s0 = 0; s1 = 0; s2 = 0;
    memread = 0; id_rt = 0; valid = 0; if_rs = 0; if_rt = 0; clr = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0; #1;
  endtask

  task automatic set_hazard();
    memread = 1; id_rt = 5'd7; if_rt = 5'd7; if_rs = 5'd0; valid = 1;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    ex_rw = 1; ex_rd = 5'd5; s0 = 5'd5; set_hazard(); #1;
    n_total++; if (mux0 !== 9'd0) $display("FAIL reset_mux act=%b exp=%b", mux0, 9'd0); else n_pass++;
    n_total++; if ({stall0, flush0, stall1, flush1} !== 4'b0) $display("FAIL reset_stall act=%b exp=0000", {stall0, flush0, stall1, flush1}); else n_pass++;
    step();
    n_total++; if ({cnt0, cnt1} !== 20'd0) $display("FAIL reset_count act=%0d/%0d exp=0/0", cnt0, cnt1); else n_pass++;
    idle(); rst = 0; #1;
    n_total++; if (stall0 !== 1'b0) $display("FAIL reset_release_stall act=%b exp=0", stall0); else n_pass++;
  endtask

  task automatic test_fwd_priority();
    idle();
    ex_rw = 1; ex_rd = 5'd5; mw_rw = 1; mw_rd = 5'd5; s0 = 5'd5; s1 = 5'd3; #1;
    n_total++; if (mux0 !== 9'b000_000_001) $display("FAIL fwd_priority act=%b exp=%b", mux0, 9'b000_000_001); else n_pass++;
    ex_rd = 5'd4; mw_rd = 5'd3; #1;
    n_total++; if (mux1 !== 6'b010_000) $display("FAIL fwd_memwb_ch1 act=%b exp=%b", mux1, 6'b010_000); else n_pass++;
    ex_rw = 0; ex_rd = 5'd5; mw_rd = 5'd5; #1;
    n_total++; if (mux0 !== 9'b000_000_010) $display("FAIL fwd_exmem_nowrite act=%b exp=%b", mux0, 9'b000_000_010); else n_pass++;
    mw_rw = 0; #1;
    n_total++; if (mux0 !== 9'd0) $display("FAIL fwd_none act=%b exp=%b", mux0, 9'd0); else n_pass++;
  endtask

  task automatic test_fwd_zero();
    idle();
    ex_rw = 1; ex_rd = 5'd0; mw_rw = 1; mw_rd = 5'd0; #1;
    n_total++; if (mux1 !== 6'd0) $display("FAIL fwd_zero act=%b exp=%b", mux1, 6'd0); else n_pass++;
  endtask

  task automatic test_fwd_ch2();
    idle();
    mw_rw = 1; mw_rd = 5'd9; s2 = 5'd9; s0 = 5'd1; s1 = 5'd2; #1;
    n_total++; if (mux0 !== 9'b010_000_000) $display("FAIL fwd_ch2 act=%b exp=%b", mux0, 9'b010_000_000); else n_pass++;
  endtask

  task automatic test_lat1();
    do_reset();
    set_hazard(); valid = 0; #1;
    n_total++; if (stall1 !== 1'b0) $display("FAIL lat1_invalid act=%b exp=0", stall1); else n_pass++;
    set_hazard(); id_rt = 5'd0; if_rt = 5'd0; #1;
    n_total++; if (stall1 !== 1'b0) $display("FAIL lat1_rt0 act=%b exp=0", stall1); else n_pass++;
    set_hazard(); #1;
    n_total++; if ({stall1, flush1} !== 2'b11) $display("FAIL lat1_stall act=%b exp=11", {stall1, flush1}); else n_pass++;
    n_total++; if (cnt1 !== 4'd0) $display("FAIL lat1_cnt_before act=%0d exp=0", cnt1); else n_pass++;
    step(); idle(); #1;
    n_total++; if ({stall1, flush1} !== 2'b00) $display("FAIL lat1_release act=%b exp=00", {stall1, flush1}); else n_pass++;
    n_total++; if (cnt1 !== 4'd1) $display("FAIL lat1_cnt act=%0d exp=1", cnt1); else n_pass++;
  endtask

  task automatic test_lat3();
    do_reset();
    set_hazard(); #1;
    n_total++; if ({stall0, flush0} !== 2'b11) $display("FAIL lat3_c1 act=%b exp=11", {stall0, flush0}); else n_pass++;
    step();
    // forwarding works during a stall
    ex_rw = 1; ex_rd = 5'd5; s0 = 5'd5; #1;
    n_total++; if ({stall0, flush0} !== 2'b11) $display("FAIL lat3_c2 act=%b exp=11", {stall0, flush0}); else n_pass++;
    n_total++; if (mux0 !== 9'b000_000_001) $display("FAIL lat3_mux_in_stall act=%b exp=%b", mux0, 9'b000_000_001); else n_pass++;
    step();
    n_total++; if ({stall0, flush0} !== 2'b11) $display("FAIL lat3_c3 act=%b exp=11", {stall0, flush0}); else n_pass++;
    step(); idle(); #1;
    n_total++; if (stall0 !== 1'b0) $display("FAIL lat3_run act=%b exp=0", stall0); else n_pass++;
    n_total++; if (cnt0 !== 16'd3) $display("FAIL lat3_cnt act=%0d exp=3", cnt0); else n_pass++;
    step();
    n_total++; if ({stall0, cnt0} !== {1'b0, 16'd3}) $display("FAIL lat3_hold act=%b/%0d exp=0/3", stall0, cnt0); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_hazard(); step();
    n_total++; if ({stall0, cnt0} !== {1'b1, 16'd1}) $display("FAIL mid_c2 act=%b/%0d exp=1/1", stall0, cnt0); else n_pass++;
    rst = 1; #1;
    n_total++; if ({stall0, flush0} !== 2'b00) $display("FAIL mid_reset_stall act=%b exp=00", {stall0, flush0}); else n_pass++;
    step(); rst = 0; idle(); #1;
    n_total++; if ({stall0, cnt0} !== {1'b0, 16'd0}) $display("FAIL mid_release act=%b/%0d exp=0/0", stall0, cnt0); else n_pass++;
    step();
    n_total++; if ({stall0, cnt0} !== {1'b0, 16'd0}) $display("FAIL mid_after act=%b/%0d exp=0/0", stall0, cnt0); else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    set_hazard();
    for (int i = 0; i < 20; i++) step();
    n_total++; if (cnt1 !== 4'd15) $display("FAIL sat_count act=%0d exp=15", cnt1); else n_pass++;
    clr = 1; #1;
    n_total++; if (stall1 !== 1'b1) $display("FAIL sat_clr_stall act=%b exp=1", stall1); else n_pass++;
    step(); clr = 0; #1;
    n_total++; if (cnt1 !== 4'd0) $display("FAIL sat_clr act=%0d exp=0", cnt1); else n_pass++;
    step();
    n_total++; if (cnt1 !== 4'd1) $display("FAIL sat_after_clr act=%0d exp=1", cnt1); else n_pass++;
    idle();
  endtask

  initial begin
    rst = 1; idle();
    step();
    test_reset();
    test_fwd_priority();
    test_fwd_zero();
    test_fwd_ch2();
    test_lat1();
    test_lat3();
    test_reset_mid_stall();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
